result_bcd_converter: RTL and testbench

- Sequential signed-binary-to-BCD converter between the calculator core (signed result) and the per-digit seven-segment encoders.
- Takes a two's-complement result on a start pulse and converts its magnitude by serial shift-add-3 (double dabble), one bit per clock.
- Presents four registered BCD digits, a sign flag, a leading-zero blank mask and an overflow flag, with a one-cycle done pulse.
- Replaces the combinational digit-split, so the display path gets registered, glitch-free digits.

---
 rtl/result_bcd_converter_pkg.sv | 6 +
 rtl/result_bcd_converter_bcd_add3.sv | 9 +
 rtl/result_bcd_converter.sv | 132 +++++++++++++
 tb/tb_result_bcd_converter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/result_bcd_converter_pkg.sv
// result_bcd_converter_pkg: shared FSM states and digit constants for the BCD display path.
package result_bcd_converter_pkg;
    typedef enum logic [1:0] {IDLE, ABS, SHIFT, DONE} state_t;
    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MINUS = 4'd10;
endpackage

// File: rtl/result_bcd_converter_bcd_add3.sv
// result_bcd_converter_bcd_add3: per-nibble add-3 correction applied before each double-dabble shift.
module result_bcd_converter_bcd_add3
    import result_bcd_converter_pkg::*;
(
    input  logic [DIGIT_W-1:0] nib_i,
    output logic [DIGIT_W-1:0] nib_o
);
    assign nib_o = nib_i >= DIGIT_W'(5) ? nib_i + DIGIT_W'(3) : nib_i;
endmodule

// File: rtl/result_bcd_converter.sv
// result_bcd_converter: serial signed-binary to BCD converter with registered digits,
// sign, overflow and leading-zero blank mask for the seven-segment path.
module result_bcd_converter
    import result_bcd_converter_pkg::*;
#(
    parameter int WIDTH      = 15,
    parameter int DIGITS     = 4,
    parameter int INT_DIGITS = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [WIDTH-1:0]          value,
    output logic                      busy,
    output logic                      done,
    output logic                      neg,
    output logic                      ovf,
    output logic [DIGIT_W*DIGITS-1:0] bcd,
    output logic [DIGITS-1:0]         blank
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam int ACC_W = DIGIT_W * INT_DIGITS;
    localparam int OUT_W = DIGIT_W * DIGITS;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   val_q, val_d, mag_q, mag_d;
    logic [ACC_W-1:0]   acc_q, acc_d, acc_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic               busy_q, busy_d, done_q, done_d, neg_q, neg_d, ovf_q, ovf_d;
    logic [OUT_W-1:0]   bcd_q, bcd_d;
    logic [DIGITS-1:0]  blank_q, blank_d;
    logic [DIGITS:0]    lz;
    logic [ACC_W+WIDTH-1:0] sh;

    for (genvar d = 0; d < INT_DIGITS; d++) begin : g_add3
        result_bcd_converter_bcd_add3 u_add3 (
            .nib_i(acc_q[DIGIT_W*d +: DIGIT_W]),
            .nib_o(acc_adj[DIGIT_W*d +: DIGIT_W])
        );
    end

    // lz[i]: output digit i and every higher output digit are zero
    always_comb begin
        lz = '0;
        lz[DIGITS] = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--)
            lz[i] = lz[i+1] & ~|acc_q[DIGIT_W*i +: DIGIT_W];
    end

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        mag_d   = mag_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        bcd_d   = bcd_q;
        blank_d = blank_q;
        sh      = {acc_adj, mag_q} << 1;
        case (state_q)
            IDLE: if (start) begin
                state_d = ABS;
                val_d   = value;
                busy_d  = 1'b1;
            end
            ABS: begin
                mag_d   = val_q[WIDTH-1] ? -val_q : val_q;
                sign_d  = val_q[WIDTH-1];
                acc_d   = '0;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                {acc_d, mag_d} = sh;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = cnt_q == CNT_W'(WIDTH - 1) ? DONE : SHIFT;
            end
            DONE: begin
                bcd_d   = acc_q[OUT_W-1:0];
                ovf_d   = |acc_q[ACC_W-1:OUT_W];
                blank_d = lz[DIGITS-1:0];
                neg_d   = sign_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            val_q   <= '0;
            mag_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            bcd_q   <= '0;
            blank_q <= '0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            mag_q   <= mag_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            bcd_q   <= bcd_d;
            blank_q <= blank_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign neg   = neg_q;
    assign ovf   = ovf_q;
    assign bcd   = bcd_q;
    assign blank = blank_q;
endmodule

// File: tb/tb_result_bcd_converter.sv
// tb_result_bcd_converter: randomized and directed checks of the converter against a
// decimal-arithmetic reference model, plus literal expectations for the boundary values.
module tb_result_bcd_converter;
    localparam int WIDTH = 15;
    localparam int DIGITS = 4;
    localparam int INT_DIGITS = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] value = '0;
    logic             busy, done, neg, ovf;
    logic [15:0]      bcd;
    logic [3:0]       blank;

    int n_chk = 0;
    int n_fail = 0;
    int done_cnt = 0;

    logic        m_busy = 1'b0, m_done = 1'b0, m_neg = 1'b0, m_ovf = 1'b0;
    logic [15:0] m_bcd = '0;
    logic [3:0]  m_blank = '0;
    logic [WIDTH-1:0] pend = '0;
    int          rem = 0;
    logic        chk_en = 1'b0;

    result_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS), .INT_DIGITS(INT_DIGITS)) dut (
        .clk(clk), .rst(rst), .start(start), .value(value),
        .busy(busy), .done(done), .neg(neg), .ovf(ovf), .bcd(bcd), .blank(blank)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // {neg, ovf, blank, bcd} from plain decimal arithmetic on the signed value
    function automatic logic [21:0] model_of(input logic [WIDTH-1:0] v);
        int sv, mag, low;
        logic [15:0] b;
        logic [3:0]  bl;
        sv  = $signed(v);
        mag = sv < 0 ? -sv : sv;
        low = mag % 10000;
        b   = '0;
        bl  = '0;
        for (int i = 0; i < 4; i++) b[4*i +: 4] = 4'((low / (10 ** i)) % 10);
        for (int i = 1; i < 4; i++) bl[i] = low < 10 ** i;
        return {sv < 0, mag > 9999, bl, b};
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_neg <= 1'b0; m_ovf <= 1'b0;
            m_bcd <= '0; m_blank <= '0; rem <= 0; chk_en <= 1'b1;
        end else begin
            m_done <= 1'b0;
            if (rem > 0) begin
                rem <= rem - 1;
                if (rem == 1) begin
                    {m_neg, m_ovf, m_blank, m_bcd} <= model_of(pend);
                    m_done <= 1'b1;
                    m_busy <= 1'b0;
                end
            end else if (start) begin
                pend   <= value;
                rem    <= WIDTH + 2;
                m_busy <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(m_done));
            check("neg", 32'(neg), 32'(m_neg));
            check("ovf", 32'(ovf), 32'(m_ovf));
            check("bcd", 32'(bcd), 32'(m_bcd));
            check("blank", 32'(blank), 32'(m_blank));
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic run_conv(input logic [WIDTH-1:0] v, input logic [15:0] eb,
                            input logic [3:0] ebl, input logic en, input logic eo);
        int c;
        @(posedge clk); #2;
        value = v;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        c = 0;
        do begin
            @(posedge clk); #1;
            c++;
        end while (!done && c < 40);
        check("latency", 32'(c), 32'd17);
        check("lit_bcd", 32'(bcd), 32'(eb));
        check("lit_blank", 32'(blank), 32'(ebl));
        check("lit_neg", 32'(neg), 32'(en));
        check("lit_ovf", 32'(ovf), 32'(eo));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int d0;
        rst = 1'b0;
        start = 1'b1;
        value = 15'd1234;
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bcd", 32'(bcd), 32'd0);
        check("rst_blank", 32'(blank), 32'd0);
        rst = 1'b1;
        start = 1'b0;
        d0 = done_cnt;
        repeat (5) @(posedge clk);
        #2;
        check("idle_no_done", 32'(done_cnt - d0), 32'd0);

        run_conv(15'd1234,       16'h1234, 4'b0000, 1'b0, 1'b0);
        run_conv(15'(-57),       16'h0057, 4'b1100, 1'b1, 1'b0);
        run_conv(15'd0,          16'h0000, 4'b1110, 1'b0, 1'b0);
        run_conv(15'd9999,       16'h9999, 4'b0000, 1'b0, 1'b0);
        run_conv(15'd10000,      16'h0000, 4'b1110, 1'b0, 1'b1);
        run_conv(15'h4000,       16'h6384, 4'b0000, 1'b1, 1'b1);
        run_conv(15'd16383,      16'h6383, 4'b0000, 1'b0, 1'b1);
        run_conv(15'(-1),        16'h0001, 4'b1110, 1'b1, 1'b0);

        // second start mid-conversion and value churn must be ignored
        @(posedge clk); #2;
        value = 15'd321; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        d0 = done_cnt;
        repeat (4) @(posedge clk);
        #2;
        value = 15'd42; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0; value = 15'd999;
        repeat (25) @(posedge clk);
        #2;
        check("single_done", 32'(done_cnt - d0), 32'd1);
        check("busy_prot_bcd", 32'(bcd), 32'h0321);

        // reset partway through a conversion aborts it
        @(posedge clk); #2;
        value = 15'd4321; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        d0 = done_cnt;
        repeat (20) @(posedge clk);
        #2;
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_bcd", 32'(bcd), 32'd0);
        check("abort_neg", 32'(neg), 32'd0);
        run_conv(15'd7, 16'h0007, 4'b1110, 1'b0, 1'b0);

        // random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #2;
            start = $urandom_range(0, 3) == 0;
            value = 15'($urandom);
            rst   = $urandom_range(0, 149) != 0;
        end
        rst = 1'b1;
        // start held high: back-to-back conversions re-sampling value
        start = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #2;
            value = 15'($urandom);
        end
        start = 1'b0;
        repeat (25) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
